fetch_exec_sequencer: RTL and testbench
=======================================

Name: fetch_exec_sequencer

Overview:
- Eight-phase instruction sequencer for the 32-bit RISC-y core.
- Decodes the 3-bit opcode from the instruction register. Generates per-phase strobes for the program counter (enable/load), memory, instruction register and accumulator, and the address-mux select.
- Sits between the instruction register and the PC/memory/ALU datapath.
- Adds halt/resume and a global stall on top of the basic fetch/execute cycle.

Parameters:
- None. Opcode map is fixed: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.

Ports:
- CLOCK  in  1  system clock; all state changes on rising edge
- RESET  in  1  asynchronous, active-low reset
- OPCODE  in  3  opcode field of instruction register
- ZERO  in  1  accumulator-is-zero flag from ALU
- STALL  in  1  active-high global stall; freezes the sequencer
- RUN  in  1  resume request while halted; sampled on rising edge
- PC_ENABLE  out  1  to program counter ENABLE
- PC_LOAD  out  1  to program counter LOAD; PC_ENABLE=1 with PC_LOAD=0 increments, both=1 loads
- SEL  out  1  address mux: 1=PC, 0=IR operand
- MEM_RD  out  1  memory read strobe
- MEM_WR  out  1  memory write strobe
- LOAD_IR  out  1  instruction register load
- LOAD_AC  out  1  accumulator load
- HALT  out  1  high while in HALTED state
- PHASE  out  4  current state encoding, for debug/verification

Behaviour:
- Interface: one clock CLOCK; reset RESET is asynchronous and active-low. RESET=0 forces state INST_ADDR immediately, regardless of clock or STALL.
- States and PHASE encoding:
  - INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3
  - OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7, HALTED=8
- Each state lasts one cycle unless stalled.
- Transitions:
  - 0→1→2→3→4.
  - 4→8 if OPCODE==HLT, else 4→5.
  - 5→6→7→0.
  - 8→8 until RUN=1 (and STALL=0), then 8→0.
- Outputs are combinational from the registered state, OPCODE and ZERO. ALUOP = OPCODE in {ADD, AND, XOR, LDA}. Outputs not listed below are 0.
  - INST_ADDR: SEL=1.
  - INST_FETCH: SEL=1, MEM_RD=1.
  - INST_LOAD, IDLE: SEL=1, MEM_RD=1, LOAD_IR=1.
  - OP_ADDR: PC_ENABLE=1, PC_LOAD=0 (increment, HLT included, so resume continues at the next instruction).
  - OP_FETCH: MEM_RD=ALUOP.
  - ALU_OP: MEM_RD=ALUOP.
    - SKZ with ZERO=1: PC_ENABLE=1, PC_LOAD=0 (skip).
    - JMP: PC_ENABLE=1, PC_LOAD=1.
  - STORE: MEM_RD=ALUOP, LOAD_AC=ALUOP, MEM_WR=(OPCODE==STO). JMP: PC_ENABLE=1, PC_LOAD=1.
  - HALTED: HALT=1, SEL=1.
- Reset values (state INST_ADDR): SEL=1, PHASE=0, all other outputs 0.
- STALL=1:
  - State holds.
  - PC_ENABLE, PC_LOAD, LOAD_IR, LOAD_AC and MEM_WR are forced to 0.
  - SEL, MEM_RD, HALT and PHASE keep their decoded values.
  - Net effect: a stalled phase never issues a side-effect more than once.
- STALL and RUN both high in HALTED: STALL wins; remain HALTED.
- RUN outside HALTED is ignored.
- ZERO is sampled only in ALU_OP. OPCODE must be stable from IDLE through STORE; the sequencer does not register it.
- Latency: 8 cycles per non-halting instruction with no stall. A halt is entered 5 cycles after INST_ADDR.
- Reset mid-instruction: all strobes drop asynchronously, and no partial MEM_WR or PC update occurs after reset assertion.

Test Plan:
- Reset, then OPCODE=LDA, ZERO=0, counter attached from PC=0:
  - PHASE steps 0..7,0.
  - MEM_RD high in phases 1-3 and 5-7; LOAD_IR high in phases 2-3; LOAD_AC high only in phase 7.
  - PC_ENABLE high only in phase 4, giving PC=1 after one instruction.
- OPCODE=SKZ:
  - ZERO=1: PC_ENABLE high in phases 4 and 6, PC 0→2.
  - ZERO=0: PC_ENABLE in phase 4 only, PC 0→1.
  - MEM_RD low in phases 5-7.
- OPCODE=JMP with counter DATA=0x15: PC_ENABLE=PC_LOAD=1 in phases 6 and 7; PC=0x15 at the next INST_ADDR.
- OPCODE=STO: MEM_WR=1 only in phase 7; MEM_RD=0 and LOAD_AC=0 in phases 5-7.
- OPCODE=HLT:
  - PC increments in phase 4, then PHASE=8 and HALT=1, held for 10 cycles.
  - RUN=1 with STALL=1: stays halted.
  - RUN=1 with STALL=0: PHASE=0 and HALT=0 on the next edge.
- Stall and reset:
  - STALL=1 for 3 cycles while in OP_ADDR: PHASE held at 4, PC increments exactly once after release.
  - RESET=0 asserted mid-cycle in ALU_OP with JMP: PHASE=0 and PC_LOAD=0 immediately, before the next edge.

Source files
------------

// File: rtl/fetch_exec_sequencer.sv
// fetch_exec_sequencer
//   Eight-phase fetch/execute sequencer with halt/resume and global stall.
//   Decodes the instruction-register opcode and produces per-phase strobes
//   for the program counter, memory, instruction register and accumulator.
//
// Ports
//   CLOCK      in   system clock, rising edge
//   RESET      in   asynchronous active-low reset (forces INST_ADDR)
//   OPCODE     in   [2:0] opcode field of the instruction register
//   ZERO       in   accumulator-is-zero flag (used only in ALU_OP)
//   STALL      in   global stall: holds state, suppresses side-effect strobes
//   RUN        in   resume request while halted
//   PC_ENABLE  out  program counter enable
//   PC_LOAD    out  program counter load (with PC_ENABLE=1)
//   SEL        out  address mux select: 1=PC, 0=IR operand
//   MEM_RD     out  memory read strobe
//   MEM_WR     out  memory write strobe
//   LOAD_IR    out  instruction register load
//   LOAD_AC    out  accumulator load
//   HALT       out  high while halted
//   PHASE      out  [3:0] current state encoding
module fetch_exec_sequencer (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [2:0] OPCODE,
  input  logic       ZERO,
  input  logic       STALL,
  input  logic       RUN,
  output logic       PC_ENABLE,
  output logic       PC_LOAD,
  output logic       SEL,
  output logic       MEM_RD,
  output logic       MEM_WR,
  output logic       LOAD_IR,
  output logic       LOAD_AC,
  output logic       HALT,
  output logic [3:0] PHASE
);

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  state_t  state;
  state_t  state_nxt;
  opcode_t op;
  logic    aluop;

  // decoded strobes before stall gating
  logic pc_enable_d;
  logic pc_load_d;
  logic mem_wr_d;
  logic load_ir_d;
  logic load_ac_d;

  assign op    = opcode_t'(OPCODE);
  assign aluop = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state <= INST_ADDR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!STALL) begin
      unique case (state)
        INST_ADDR:  state_nxt = INST_FETCH;
        INST_FETCH: state_nxt = INST_LOAD;
        INST_LOAD:  state_nxt = IDLE;
        IDLE:       state_nxt = OP_ADDR;
        OP_ADDR:    state_nxt = (op == OP_HLT) ? HALTED : OP_FETCH;
        OP_FETCH:   state_nxt = ALU_OP;
        ALU_OP:     state_nxt = STORE;
        STORE:      state_nxt = INST_ADDR;
        HALTED:     state_nxt = RUN ? INST_ADDR : HALTED;
        default:    state_nxt = INST_ADDR;
      endcase
    end
  end

  always_comb begin
    pc_enable_d = 1'b0;
    pc_load_d   = 1'b0;
    mem_wr_d    = 1'b0;
    load_ir_d   = 1'b0;
    load_ac_d   = 1'b0;
    SEL         = 1'b0;
    MEM_RD      = 1'b0;
    HALT        = 1'b0;
    unique case (state)
      INST_ADDR: SEL = 1'b1;
      INST_FETCH: begin
        SEL    = 1'b1;
        MEM_RD = 1'b1;
      end
      INST_LOAD, IDLE: begin
        SEL       = 1'b1;
        MEM_RD    = 1'b1;
        load_ir_d = 1'b1;
      end
      // PC advances here even for HLT so a resume continues at the next word
      OP_ADDR: pc_enable_d = 1'b1;
      OP_FETCH: MEM_RD = aluop;
      ALU_OP: begin
        MEM_RD = aluop;
        if (op == OP_SKZ && ZERO) pc_enable_d = 1'b1;
        if (op == OP_JMP) begin
          pc_enable_d = 1'b1;
          pc_load_d   = 1'b1;
        end
      end
      STORE: begin
        MEM_RD    = aluop;
        load_ac_d = aluop;
        mem_wr_d  = (op == OP_STO);
        if (op == OP_JMP) begin
          pc_enable_d = 1'b1;
          pc_load_d   = 1'b1;
        end
      end
      HALTED: begin
        HALT = 1'b1;
        SEL  = 1'b1;
      end
      default: SEL = 1'b1;
    endcase
  end

  // a held phase must not repeat a side effect, so only state-changing
  // strobes are gated; SEL/MEM_RD/HALT stay as decoded
  assign PC_ENABLE = pc_enable_d & ~STALL;
  assign PC_LOAD   = pc_load_d   & ~STALL;
  assign MEM_WR    = mem_wr_d    & ~STALL;
  assign LOAD_IR   = load_ir_d   & ~STALL;
  assign LOAD_AC   = load_ac_d   & ~STALL;
  assign PHASE     = state;

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// tb_fetch_exec_sequencer
//   Directed test-plan sequences followed by randomized stimulus, checked
//   against a phase-level reference model and a program-counter model driven
//   by the sequencer's PC strobes.
module tb_fetch_exec_sequencer;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3,
                         XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;
  localparam logic [7:0] JUMP_DATA = 8'h15;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic [2:0] OPCODE = 3'd0;
  logic       ZERO = 1'b0;
  logic       STALL = 1'b0;
  logic       RUN = 1'b0;
  logic       PC_ENABLE, PC_LOAD, SEL, MEM_RD, MEM_WR, LOAD_IR, LOAD_AC, HALT;
  logic [3:0] PHASE;

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;

  int          mph;          // model phase
  logic [7:0]  pc;           // program counter attached to the strobes
  logic [7:0]  pc_start;     // PC at the start of the current instruction
  logic [7:0]  pc_exp;
  bit          pc_due;
  bit          z_inst;       // ZERO seen by the model in the unstalled ALU_OP

  fetch_exec_sequencer dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .OPCODE    (OPCODE),
    .ZERO      (ZERO),
    .STALL     (STALL),
    .RUN       (RUN),
    .PC_ENABLE (PC_ENABLE),
    .PC_LOAD   (PC_LOAD),
    .SEL       (SEL),
    .MEM_RD    (MEM_RD),
    .MEM_WR    (MEM_WR),
    .LOAD_IR   (LOAD_IR),
    .LOAD_AC   (LOAD_AC),
    .HALT      (HALT),
    .PHASE     (PHASE)
  );

  always #5 CLOCK = ~CLOCK;

  // program counter as it would sit in the datapath
  always @(posedge CLOCK) begin
    if (PC_ENABLE) pc <= PC_LOAD ? JUMP_DATA : pc + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // {PC_ENABLE,PC_LOAD,SEL,MEM_RD,MEM_WR,LOAD_IR,LOAD_AC,HALT} expected in phase ph
  function automatic logic [7:0] exp_out(input int ph, input logic [2:0] op,
                                         input bit z, input bit s);
    bit alu, en, ld, sel, rd, wr, ir, ac, hl;
    alu = (op inside {ADD, AND_, XOR_, LDA});
    sel = (ph inside {0, 1, 2, 3, 8});
    rd  = (ph inside {1, 2, 3}) || ((ph inside {5, 6, 7}) && alu);
    ir  = !s && (ph inside {2, 3});
    ac  = !s && ph == 7 && alu;
    wr  = !s && ph == 7 && op == STO;
    ld  = !s && (ph inside {6, 7}) && op == JMP;
    en  = !s && (ph == 4 || ld || (ph == 6 && op == SKZ && z));
    hl  = (ph == 8);
    return {en, ld, sel, rd, wr, ir, ac, hl};
  endfunction

  function automatic logic [7:0] dut_out();
    return {PC_ENABLE, PC_LOAD, SEL, MEM_RD, MEM_WR, LOAD_IR, LOAD_AC, HALT};
  endfunction

  // one clock cycle: drive inputs after the falling edge, check, advance model
  task automatic cyc(input bit s, input bit r, input logic [2:0] op, input bit z);
    @(negedge CLOCK);
    STALL = s; RUN = r; OPCODE = op; ZERO = z;
    #1;
    if (mph == 0) begin
      if (pc_due) begin
        check("pc_after_instr", {24'd0, pc}, {24'd0, pc_exp});
        pc_due = 0;
      end
      pc_start = pc;
    end
    check("phase", {28'd0, PHASE}, mph);
    check($sformatf("strobes_ph%0d_op%0d", mph, op), {24'd0, dut_out()},
          {24'd0, exp_out(mph, op, z, s)});
    if (!s) begin
      if (mph == 6) z_inst = z;
      case (mph)
        4: mph = (op == HLT) ? 8 : 5;
        7: begin
          mph    = 0;
          pc_due = 1;
          if (op == JMP)              pc_exp = JUMP_DATA;
          else if (op == SKZ && z_inst) pc_exp = pc_start + 8'd2;
          else                        pc_exp = pc_start + 8'd1;
        end
        8: if (r) begin
          mph    = 0;
          pc_due = 1;
          pc_exp = pc_start + 8'd1;
        end
        default: mph = mph + 1;
      endcase
    end
  endtask

  // reset asserted between clock edges, held across one rising edge
  task automatic mid_reset();
    #1 RESET = 1'b0;
    #1;
    check("rst_phase_async", {28'd0, PHASE}, 0);
    check("rst_pc_load_async", {31'd0, PC_LOAD}, 0);
    check("rst_strobes_async", {24'd0, dut_out()}, 32'h20);
    @(posedge CLOCK);
    #1;
    check("rst_phase_held", {28'd0, PHASE}, 0);
    #1 RESET = 1'b1;
    mph    = 0;
    pc_due = 0;
  endtask

  initial begin
    mph = 0; pc = 8'd0; pc_start = 8'd0; pc_exp = 8'd0; pc_due = 0; z_inst = 0;
    repeat (2) @(posedge CLOCK);
    #1;
    check("reset_phase", {28'd0, PHASE}, 0);
    check("reset_strobes", {24'd0, dut_out()}, 32'h20);
    #1 RESET = 1'b1;

    // directed test-plan sequences
    repeat (8) cyc(0, 0, LDA, 0);
    repeat (8) cyc(0, 0, SKZ, 1);
    repeat (8) cyc(0, 0, SKZ, 0);
    repeat (8) cyc(0, 0, JMP, 0);
    repeat (8) cyc(0, 0, STO, 0);
    repeat (5) cyc(0, 0, HLT, 0);
    repeat (10) cyc(0, 0, HLT, 0);
    repeat (2) cyc(1, 1, HLT, 0);
    cyc(0, 1, HLT, 0);
    repeat (4) cyc(0, 0, ADD, 0);
    repeat (3) cyc(1, 0, ADD, 0);
    repeat (4) cyc(0, 0, ADD, 0);
    repeat (7) cyc(0, 0, JMP, 0);
    mid_reset();

    // randomized: opcode/zero only change before IDLE so they stay stable
    // through the execute phases
    begin
      logic [2:0] op;
      bit z;
      op = LDA; z = 0;
      for (int unsigned i = 0; i < 3000; i++) begin
        if (mph inside {0, 1, 2}) begin
          op = 3'($urandom_range(0, 7));
          z  = 1'($urandom_range(0, 1));
        end
        cyc($urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, op, z);
        if ($urandom_range(0, 299) == 0) mid_reset();
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
